// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - shared EXU types and constants for the multiply writeback buffer
package el2_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } el2_mul_wb_pkt_t;

    localparam int MUL_WB_DEPTH_MIN = 2;
    localparam int MUL_WB_DEPTH_MAX = 4;

    function automatic bit mul_wb_depth_legal(input int depth);
        return (depth == MUL_WB_DEPTH_MIN) || (depth == MUL_WB_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/el2_exu_mul_wb_fifo.sv
// rtl/el2_exu_mul_wb_fifo.sv - entry storage, pointers and occupancy of the multiply writeback queue
module el2_exu_mul_wb_fifo
    import el2_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  scan_mode,
    input  logic                  wr_en,
    input  logic [4:0]            wr_rd,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    output el2_mul_wb_pkt_t       head,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_rd
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [CW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                   wr_ok, rd_ok, overflow;
    logic [DEPTH-1:0][31:0] ent_data;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == LAST) ? '0 : p + CW'(1);
    endfunction

    // A pop in the same cycle frees the slot, so a push into a full queue is only lost without one.
    assign rd_ok     = rd_en & (count != '0);
    assign overflow  = wr_en & (count == FULL) & ~rd_ok;
    assign wr_ok     = wr_en & ~overflow;

    assign wr_ptr_nxt = ptr_inc(wr_ptr);
    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign count_nxt  = count + CW'(wr_ok) - CW'(rd_ok);

    rvdffs #(.WIDTH(CW)) u_wr_ptr (.din(wr_ptr_nxt), .en(wr_ok),         .clk(clk), .rst_l(rst_l), .dout(wr_ptr));
    rvdffs #(.WIDTH(CW)) u_rd_ptr (.din(rd_ptr_nxt), .en(rd_ok),         .clk(clk), .rst_l(rst_l), .dout(rd_ptr));
    rvdffs #(.WIDTH(CW)) u_count  (.din(count_nxt),  .en(wr_ok | rd_ok), .clk(clk), .rst_l(rst_l), .dout(count));

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic        we, clr;
        logic [36:0] q;

        assign we  = wr_ok & (wr_ptr[AW-1:0] == AW'(i));
        assign clr = rd_ok & (rd_ptr[AW-1:0] == AW'(i));

        // When full, wr_ptr and rd_ptr share a slot; the write keeps it valid.
        rvdffs #(.WIDTH(1)) u_valid (
            .din(we), .en(we | clr), .clk(clk), .rst_l(rst_l), .dout(ent_valid[i])
        );

        rvdffe #(.WIDTH(37)) u_data (
            .din({wr_rd, wr_data}), .en(we), .clk(clk), .rst_l(rst_l),
            .scan_mode(scan_mode), .dout(q)
        );

        assign ent_rd[i]   = q[36:32];
        assign ent_data[i] = q[31:0];
    end

    always_comb begin
        head       = '0;
        head.valid = ent_valid[rd_ptr[AW-1:0]];
        head.rd    = ent_rd[rd_ptr[AW-1:0]];
        head.data  = ent_data[rd_ptr[AW-1:0]];
    end

    a_depth_legal: assert property (@(posedge clk) mul_wb_depth_legal(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l) !overflow);

endmodule

// File: rtl/el2_lib.sv
// rtl/el2_lib.sv - enable flop primitives shared across the EXU
module rvdffs #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end
endmodule

// Stands in for a clock-gated flop bank; scan forces the gate open.
module rvdffe #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    output logic [WIDTH-1:0] dout
);
    logic gate_en;

    assign gate_en = en | scan_mode;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dout <= '0;
        end else if (gate_en) begin
            dout <= din;
        end
    end
endmodule

// File: rtl/el2_exu_mul_wb.sv
// rtl/el2_exu_mul_wb.sv - multiply writeback buffer; RV_MUL_WB_BYPASS_EN enables same-cycle bypass
module el2_exu_mul_wb
    import el2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        scan_mode,
    input  logic        mul_valid_x,
    input  logic [4:0]  mul_rd_x,
    input  logic [31:0] mul_result_x,
    input  logic        flush_x,
    input  logic        wb_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mul_stall,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    el2_mul_wb_pkt_t          head;
    logic [CW-1:0]            count, count_nxt;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][4:0]    ent_rd;
    logic                     push, pop, push_store, pop_store, bypass, hit_store;

    assign push = mul_valid_x & ~flush_x & (mul_rd_x != 5'd0);

`ifdef RV_MUL_WB_BYPASS_EN
    assign bypass = push & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        if (bypass) begin
            wb_valid = 1'b1;
            wb_rd    = mul_rd_x;
            wb_data  = mul_result_x;
        end else if (head.valid) begin
            wb_valid = 1'b1;
            wb_rd    = head.rd;
            wb_data  = head.data;
        end
    end

    // A bypassed result that is granted immediately never touches storage.
    assign pop        = wb_valid & wb_ready;
    assign pop_store  = pop & ~bypass;
    assign push_store = push & ~(bypass & wb_ready);

    assign count_nxt = count + CW'(push_store) - CW'(pop_store);
    assign mul_stall = (count_nxt >= FULL) | (count == FULL);

    always_comb begin
        hit_store = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_store = hit_store | (ent_valid[i] & (ent_rd[i] == chk_addr));
        end
    end

    assign chk_hit = (chk_addr != 5'd0) & (hit_store | (bypass & (mul_rd_x == chk_addr)));

    el2_exu_mul_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .scan_mode (scan_mode),
        .wr_en     (push_store),
        .wr_rd     (mul_rd_x),
        .wr_data   (mul_result_x),
        .rd_en     (pop_store),
        .head      (head),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

endmodule

// File: tb/tb_el2_exu_mul_wb.sv
// tb/tb_el2_exu_mul_wb.sv - self-checking bench for el2_exu_mul_wb
module tb_el2_exu_mul_wb;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_l, scan_mode, mul_valid_x, flush_x, wb_ready;
    logic [4:0]  mul_rd_x, chk_addr, wb_rd;
    logic [31:0] mul_result_x, wb_data;
    logic        wb_valid, mul_stall, chk_hit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic        mv, fl;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rdy;
        logic [4:0]  chk;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_stall, e_hit;
    } vec_t;
    vec_t tbl[$];

    el2_exu_mul_wb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode),
        .mul_valid_x(mul_valid_x), .mul_rd_x(mul_rd_x), .mul_result_x(mul_result_x),
        .flush_x(flush_x), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mul_stall(mul_stall), .chk_addr(chk_addr), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic mv, fl, input logic [4:0] rd, input logic [31:0] data,
                       input logic rdy, input logic [4:0] chk,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic es, input logic eh);
        vec_t v;
        v.mv = mv; v.fl = fl; v.rd = rd; v.data = data; v.rdy = rdy; v.chk = chk;
        v.e_valid = ev; v.e_rd = erd; v.e_data = ed; v.e_stall = es; v.e_hit = eh;
        tbl.push_back(v);
    endtask

    // One cycle: drive, compare against the queue model (and the table row if given), clock, update model.
    task automatic step(input logic mv, fl, input logic [4:0] rd, input logic [31:0] data,
                        input logic rdy, input logic [4:0] chk, input int tidx);
        logic        push, byp, ev, es, eh, pop;
        logic [4:0]  erd;
        logic [31:0] ed;
        int          occ_next;
        string       tag;
        mul_valid_x = mv; flush_x = fl; mul_rd_x = rd; mul_result_x = data;
        wb_ready = rdy; chk_addr = chk;
        #4;
        tag  = (tidx >= 0) ? $sformatf("v%0d", tidx) : "rnd";
        push = mv && !fl && (rd != 0);
        byp  = 1'b0;
`ifdef RV_MUL_WB_BYPASS_EN
        byp  = push && (q.size() == 0);
`endif
        if (byp) begin
            ev = 1'b1; erd = rd; ed = data;
        end else if (q.size() > 0) begin
            ev = 1'b1; erd = q[0].rd; ed = q[0].data;
        end else begin
            ev = 1'b0; erd = '0; ed = '0;
        end
        pop      = ev && rdy;
        occ_next = q.size() + ((push && !(byp && pop)) ? 1 : 0) - ((pop && !byp) ? 1 : 0);
        es       = (occ_next >= DEPTH) || (q.size() == DEPTH);
        eh       = 1'b0;
        if (chk != 0) begin
            foreach (q[i]) if (q[i].rd == chk) eh = 1'b1;
            if (byp && rd == chk) eh = 1'b1;
        end
        check({tag, " wb_valid"}, wb_valid, ev);
        check({tag, " wb_rd"}, wb_rd, erd);
        check({tag, " wb_data"}, wb_data, ed);
        check({tag, " mul_stall"}, mul_stall, es);
        check({tag, " chk_hit"}, chk_hit, eh);
        check({tag, " count"}, dut.u_fifo.count, q.size());
`ifndef RV_MUL_WB_BYPASS_EN
        if (tidx >= 0) begin
            check({tag, " tbl wb_valid"}, wb_valid, tbl[tidx].e_valid);
            check({tag, " tbl wb_rd"}, wb_rd, tbl[tidx].e_rd);
            check({tag, " tbl wb_data"}, wb_data, tbl[tidx].e_data);
            check({tag, " tbl mul_stall"}, mul_stall, tbl[tidx].e_stall);
            check({tag, " tbl chk_hit"}, chk_hit, tbl[tidx].e_hit);
        end
`endif
        @(posedge clk);
        if (pop && !byp) void'(q.pop_front());
        if (push && !(byp && pop)) q.push_back('{rd, data});
        #1;
    endtask

    initial begin
        rst_l = 1'b0; scan_mode = 1'b0; mul_valid_x = 1'b0; flush_x = 1'b0;
        mul_rd_x = '0; mul_result_x = '0; wb_ready = 1'b0; chk_addr = '0;

        //   mv fl rd  data           rdy chk   valid rd  data           stall hit
        add(0, 0, 0,  32'h0,          1,  0,    0,    0,  32'h0,         0,    0);
        add(1, 0, 5,  32'h1234_5678,  1,  5,    0,    0,  32'h0,         0,    0);
        add(0, 0, 0,  32'h0,          1,  5,    1,    5,  32'h1234_5678, 0,    1);
        add(0, 0, 0,  32'h0,          1,  5,    0,    0,  32'h0,         0,    0);
        add(1, 0, 1,  32'hA,          0,  0,    0,    0,  32'h0,         0,    0);
        add(1, 0, 2,  32'hB,          0,  0,    1,    1,  32'hA,         1,    0);
        add(0, 0, 0,  32'h0,          0,  2,    1,    1,  32'hA,         1,    1);
        add(0, 0, 0,  32'h0,          1,  2,    1,    1,  32'hA,         1,    1);
        add(0, 0, 0,  32'h0,          0,  2,    1,    2,  32'hB,         0,    1);
        add(1, 0, 3,  32'hC,          1,  2,    1,    2,  32'hB,         0,    1);
        add(1, 0, 4,  32'hD,          0,  2,    1,    3,  32'hC,         1,    0);
        add(1, 0, 6,  32'hE,          1,  0,    1,    3,  32'hC,         1,    0);
        add(0, 0, 0,  32'h0,          0,  6,    1,    4,  32'hD,         1,    1);
        add(1, 1, 7,  32'hF,          0,  0,    1,    4,  32'hD,         1,    0);
        add(0, 0, 0,  32'h0,          1,  7,    1,    4,  32'hD,         1,    0);
        add(1, 0, 0,  32'h9,          1,  0,    1,    6,  32'hE,         0,    0);
        add(0, 0, 0,  32'h0,          1,  0,    0,    0,  32'h0,         0,    0);
        add(1, 1, 9,  32'h99,         1,  0,    0,    0,  32'h0,         0,    0);
        add(0, 0, 0,  32'h0,          1,  9,    0,    0,  32'h0,         0,    0);
        add(1, 0, 7,  32'h77,         0,  7,    0,    0,  32'h0,         0,    0);
        add(0, 0, 0,  32'h0,          0,  7,    1,    7,  32'h77,        0,    1);
        add(0, 0, 0,  32'h0,          1,  7,    1,    7,  32'h77,        0,    1);
        add(0, 0, 0,  32'h0,          1,  7,    0,    0,  32'h0,         0,    0);

        repeat (2) @(posedge clk);
        #1;
        check("reset wb_valid", wb_valid, 1'b0);
        check("reset wb_rd", wb_rd, 5'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset mul_stall", mul_stall, 1'b0);
        check("reset chk_hit", chk_hit, 1'b0);
        check("reset count", dut.u_fifo.count, 0);
        rst_l = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].mv, tbl[i].fl, tbl[i].rd, tbl[i].data, tbl[i].rdy, tbl[i].chk, i);
        end

        for (int n = 0; n < 400; n++) begin
            logic        mv, fl, rdy;
            logic [4:0]  rd, chk;
            mv  = ($urandom % 3) != 0;
            fl  = ($urandom % 8) == 0;
            rd  = 5'($urandom_range(0, 7));
            rdy = $urandom % 2;
            chk = 5'($urandom_range(0, 7));
            if (q.size() == DEPTH && !rdy) mv = 1'b0;
            step(mv, fl, rd, $urandom, rdy, chk, -1);
        end

        for (int n = 0; n < 8 && q.size() > 0; n++) step(0, 0, 0, 0, 1, 0, -1);
        check("drain empty", q.size(), 0);

        // Reset with two committed entries: everything is lost at once.
        step(1, 0, 10, 32'hAAAA_0001, 0, 0, -1);
        step(1, 0, 11, 32'hBBBB_0002, 0, 0, -1);
        mul_valid_x = 1'b0; chk_addr = 5'd10;
        #2;
        rst_l = 1'b0;
        #1;
        q.delete();
        check("midrst wb_valid", wb_valid, 1'b0);
        check("midrst wb_rd", wb_rd, 5'd0);
        check("midrst wb_data", wb_data, 32'd0);
        check("midrst mul_stall", mul_stall, 1'b0);
        check("midrst chk_hit", chk_hit, 1'b0);
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        step(0, 0, 0, 0, 1, 10, -1);
        step(0, 0, 0, 0, 1, 11, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
